regfile_dump_reader: RTL

// - Bus-side reader of the MIPS 32x32 register file: on request, sweeps registers 0..31 through
//   one register-file read port and streams each {index, data} beat out on a valid/ready channel.
// - Replaces simulation-only file dumps with a synthesizable debug/trace stream.
// - Sits beside the register file, sharing read port 1 through a debug mux that the CPU top owns.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_dump_reader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the dump FSM state type for the register-file dump reader.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] LAST_REG = 5'd31;

  // Holds READ_LAT-1 for every supported read latency (1..4).
  localparam int WAIT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    CAPT,
    SEND,
    DONE
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Sweeps registers 0..LAST_REG through one register-file read port and streams {index, data} beats.
// Optional REGFILE_DUMP_AUTOSTART_EN: register-file writes start a dump or re-arm one while busy.
//
//   state | meaning
//   IDLE  | waiting for start (or autostart request / pending)
//   ADDR  | index on the read port, waiting out READ_LAT
//   CAPT  | read data captured into the beat registers
//   SEND  | beat valid, held stable until accepted
//   DONE  | sweep finished, index rewinds; done pulses on the following cycle
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              regwrite,
  output logic [ADDR_W-1:0] rf_read_register,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_index,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LAT - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pending_q, pending_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] beat_idx_q, beat_idx_d;
  logic [DATA_W-1:0] beat_data_q, beat_data_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              auto_req;
  logic              go;

`ifdef REGFILE_DUMP_AUTOSTART_EN
  assign auto_req = regwrite;
`else
  logic unused_regwrite;
  assign auto_req        = 1'b0;
  assign unused_regwrite = regwrite;
`endif

  assign go = start | auto_req | pending_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    pending_d   = pending_q;
    valid_d     = valid_q;
    beat_idx_d  = beat_idx_q;
    beat_data_d = beat_data_q;
    last_d      = last_q;
    // Registered from the DONE state so the pulse lands one cycle after DONE is entered.
    done_d      = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = ADDR;
          idx_d     = '0;
          wait_d    = WAIT_LOAD;
          pending_d = 1'b0;
        end
      end
      ADDR: begin
        if (wait_q == '0) begin
          state_d = CAPT;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      CAPT: begin
        valid_d     = 1'b1;
        beat_idx_d  = idx_q;
        beat_data_d = rf_read_data;
        last_d      = (idx_q == LAST_IDX);
        state_d     = SEND;
      end
      SEND: begin
        if (dump_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            wait_d  = WAIT_LOAD;
            state_d = ADDR;
          end
        end
      end
      DONE: begin
        idx_d = '0;
        if (pending_q) begin
          pending_d = 1'b0;
          wait_d    = WAIT_LOAD;
          state_d   = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A write landing during a sweep re-arms it; only reachable when autostart is built in.
    if (auto_req && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wait_q      <= '0;
      pending_q   <= 1'b0;
      valid_q     <= 1'b0;
      beat_idx_q  <= '0;
      beat_data_q <= '0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      beat_idx_q  <= beat_idx_d;
      beat_data_q <= beat_data_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  assign rf_read_register = idx_q;
  assign dump_valid       = valid_q;
  assign dump_index       = beat_idx_q;
  assign dump_data        = beat_data_q;
  assign dump_last        = last_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_q;

endmodule
